// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states, default widths.
package mdu_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int MDUOP_WIDTH = 4;

    localparam logic [MDUOP_WIDTH-1:0] MDU_MULT  = 4'd0;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MULTU = 4'd1;
    localparam logic [MDUOP_WIDTH-1:0] MDU_DIV   = 4'd2;
    localparam logic [MDUOP_WIDTH-1:0] MDU_DIVU  = 4'd3;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MTHI  = 4'd4;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MTLO  = 4'd5;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MFHI  = 4'd6;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MFLO  = 4'd7;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MADD  = 4'd8;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MADDU = 4'd9;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MSUB  = 4'd10;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MSUBU = 4'd11;

    typedef enum logic [1:0] {
        MDU_S_IDLE = 2'd0,
        MDU_S_MUL  = 2'd1,
        MDU_S_DIV  = 2'd2,
        MDU_S_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0]   trial;
    logic [W-1:0] diff;

    always_comb begin
        trial = {rem, dividend_bit};
        q_bit = (trial >= {1'b0, divisor});
        // When the subtract succeeds the true difference is below 2^W, so the
        // low W bits are exact; a zero divisor simply passes the dividend through.
        diff     = trial[W-1:0] - divisor;
        rem_next = q_bit ? diff : trial[W-1:0];
    end

endmodule

// File: rtl/mdu.sv
// Iterative radix-2 multiply/divide unit owning HI/LO.
// Optional build macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu
    import mdu_pkg::*;
#(
    parameter  int W     = WORD_WIDTH,
    localparam int CNT_W = $clog2(W) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MDUOP_WIDTH-1:0] mdu_op,
    input  logic [W-1:0]           op1,
    input  logic [W-1:0]           op2,
    input  logic                   flush,
    output logic                   busy,
    output logic                   done,
    output logic [W-1:0]           hi,
    output logic [W-1:0]           lo
);

    mdu_state_e     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] acc_reg;
    logic [W-1:0]   hi_reg, lo_reg;
    logic           done_reg;
    logic           is_div_reg, neg_q_reg, neg_r_reg;

    logic           is_mul_op, is_div_op, is_signed_op;
    logic           sign1, sign2;
    logic [W-1:0]   op1_abs, op2_abs;
    logic [2*W-1:0] mul_acc_next;
    logic [2*W-1:0] prod_fix;
    logic [2*W-1:0] mul_result;
    logic [W-1:0]   q_fix, r_fix;
    logic [W-1:0]   div_rem_next;
    logic           div_q_bit;
    logic           idle_cmd;

`ifdef MDU_MADD_EN
    logic is_acc_op, is_sub_op;
    logic acc_en_reg, acc_sub_reg;
`endif

    // Operation decode
    always_comb begin
        is_mul_op    = 1'b0;
        is_div_op    = 1'b0;
        is_signed_op = 1'b0;
`ifdef MDU_MADD_EN
        is_acc_op    = 1'b0;
        is_sub_op    = 1'b0;
`endif
        case (mdu_op)
            MDU_MULT:  begin is_mul_op = 1'b1; is_signed_op = 1'b1; end
            MDU_MULTU: is_mul_op = 1'b1;
            MDU_DIV:   begin is_div_op = 1'b1; is_signed_op = 1'b1; end
            MDU_DIVU:  is_div_op = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin is_mul_op = 1'b1; is_signed_op = 1'b1; is_acc_op = 1'b1; end
            MDU_MADDU: begin is_mul_op = 1'b1; is_acc_op = 1'b1; end
            MDU_MSUB:  begin is_mul_op = 1'b1; is_signed_op = 1'b1; is_acc_op = 1'b1; is_sub_op = 1'b1; end
            MDU_MSUBU: begin is_mul_op = 1'b1; is_acc_op = 1'b1; is_sub_op = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        sign1    = is_signed_op & op1[W-1];
        sign2    = is_signed_op & op2[W-1];
        op1_abs  = sign1 ? -op1 : op1;
        op2_abs  = sign2 ? -op2 : op2;
        idle_cmd = (state_reg == MDU_S_IDLE) && start && !flush;
    end

    // MSB-first shift-add: the accumulator doubles each step before the partial product lands.
    always_comb begin
        mul_acc_next = {acc_reg[2*W-2:0], 1'b0} + (b_reg[W-1] ? {{W{1'b0}}, a_reg} : {2*W{1'b0}});
    end

    mdu_div_step #(.W(W)) u_div_step (
        .rem          (acc_reg[W-1:0]),
        .dividend_bit (a_reg[W-1]),
        .divisor      (b_reg),
        .rem_next     (div_rem_next),
        .q_bit        (div_q_bit)
    );

    always_comb begin
        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        q_fix    = neg_q_reg ? -a_reg : a_reg;
        r_fix    = neg_r_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
        mul_result = prod_fix;
`ifdef MDU_MADD_EN
        if (acc_en_reg)
            mul_result = acc_sub_reg ? ({hi_reg, lo_reg} - prod_fix) : ({hi_reg, lo_reg} + prod_fix);
`endif
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = MDU_S_IDLE;
        end else begin
            case (state_reg)
                MDU_S_IDLE: begin
                    if (start && is_mul_op)      state_next = MDU_S_MUL;
                    else if (start && is_div_op) state_next = MDU_S_DIV;
                end
                MDU_S_MUL, MDU_S_DIV: begin
                    if (cnt_reg == '0) state_next = MDU_S_FIX;
                end
                MDU_S_FIX: state_next = MDU_S_IDLE;
                default:   state_next = MDU_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= MDU_S_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
`ifdef MDU_MADD_EN
            acc_en_reg  <= 1'b0;
            acc_sub_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (idle_cmd) begin
                if (is_mul_op || is_div_op) begin
                    a_reg      <= op1_abs;
                    b_reg      <= op2_abs;
                    acc_reg    <= '0;
                    cnt_reg    <= CNT_W'(W - 1);
                    is_div_reg <= is_div_op;
                    neg_q_reg  <= sign1 ^ sign2;
                    neg_r_reg  <= sign1;
`ifdef MDU_MADD_EN
                    acc_en_reg  <= is_acc_op;
                    acc_sub_reg <= is_sub_op;
`endif
                end
                if (mdu_op == MDU_MTHI) hi_reg <= op1;
                if (mdu_op == MDU_MTLO) lo_reg <= op1;
            end else if (!flush) begin
                case (state_reg)
                    MDU_S_MUL: begin
                        acc_reg <= mul_acc_next;
                        b_reg   <= {b_reg[W-2:0], 1'b0};
                        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
                    end
                    MDU_S_DIV: begin
                        // Quotient bits enter a_reg from the bottom as dividend bits leave the top.
                        acc_reg[W-1:0] <= div_rem_next;
                        a_reg          <= {a_reg[W-2:0], div_q_bit};
                        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
                    end
                    MDU_S_FIX: begin
                        done_reg <= 1'b1;
                        if (is_div_reg) begin
                            lo_reg <= q_fix;
                            hi_reg <= r_fix;
                        end else begin
                            {hi_reg, lo_reg} <= mul_result;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state_reg != MDU_S_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the multiply/divide unit (W=32).
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] op1, op2;
    logic        flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mdu dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mdu_op (mdu_op),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Drive a start pulse at the current negedge; operands are scrambled afterwards.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu_op = op; op1 = a; op2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op1 = $urandom; op2 = $urandom; mdu_op = MDU_MFLO;
    endtask

    // Wait (bounded) for done; stops at the negedge where done is seen.
    task automatic wait_done(output int busy_cycles, output bit got_done,
                             output logic [31:0] h, output logic [31:0] l);
        busy_cycles = 0; got_done = 1'b0; h = 'x; l = 'x;
        for (int i = 0; i < 100 && !got_done; i++) begin
            if (done) begin
                got_done = 1'b1; h = hi; l = lo;
            end else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; mdu_op = MDU_MFHI; op1 = '0; op2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    endtask

    task automatic test_mult();
        int cyc; bit got; logic [31:0] h, l;
        launch(MDU_MULT, 32'hFFFFFFFD, 32'd7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_rise: got %b want 1", busy); end
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL mult_timeout: got done=%b want 1", got); end
        checks++; if (cyc != 33) begin errors++; $display("FAIL mult_latency: got %0d busy cycles want 33", cyc); end
        checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", h); end
        checks++; if (l !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", l); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", done); end
        $display("MULT -3*7: hi=%h lo=%h busy_cycles=%0d", h, l, cyc);
    endtask

    task automatic test_multu();
        int cyc; bit got; logic [31:0] h, l;
        launch(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || h !== 32'hFFFFFFFE || l !== 32'h00000001) begin
            errors++; $display("FAIL multu_max: got done=%b hi=%h lo=%h want hi=fffffffe lo=00000001", got, h, l);
        end
        $display("MULTU ffffffff*ffffffff: hi=%h lo=%h", h, l);
    endtask

    task automatic test_div();
        int cyc; bit got; logic [31:0] h, l;
        launch(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || l !== 32'hFFFFFFFD || h !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL div_neg_dividend: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", h, l);
        end
        checks++; if (cyc != 33) begin errors++; $display("FAIL div_latency: got %0d want 33", cyc); end
        $display("DIV -7/2: hi=%h lo=%h", h, l);
        launch(MDU_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || l !== 32'hFFFFFFFD || h !== 32'h00000001) begin
            errors++; $display("FAIL div_neg_divisor: got hi=%h lo=%h want hi=00000001 lo=fffffffd", h, l);
        end
        $display("DIV 7/-2: hi=%h lo=%h", h, l);
        launch(MDU_DIVU, 32'd100, 32'd7);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || l !== 32'd14 || h !== 32'd2) begin
            errors++; $display("FAIL divu_basic: got hi=%h lo=%h want hi=2 lo=14", h, l);
        end
        $display("DIVU 100/7: hi=%h lo=%h", h, l);
    endtask

    task automatic test_div_zero();
        int cyc; bit got; logic [31:0] h, l;
        launch(MDU_DIVU, 32'd7, 32'd0);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || l !== 32'hFFFFFFFF || h !== 32'd7) begin
            errors++; $display("FAIL divu_by_zero: got hi=%h lo=%h want hi=7 lo=ffffffff", h, l);
        end
        checks++; if (cyc != 33) begin errors++; $display("FAIL divzero_latency: got %0d want 33", cyc); end
        $display("DIVU 7/0: hi=%h lo=%h", h, l);
        launch(MDU_DIV, 32'hFFFFFFFB, 32'd0);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || l !== 32'd1 || h !== 32'hFFFFFFFB) begin
            errors++; $display("FAIL div_neg_by_zero: got hi=%h lo=%h want hi=fffffffb lo=1", h, l);
        end
        $display("DIV -5/0: hi=%h lo=%h", h, l);
        launch(MDU_DIV, 32'd5, 32'd0);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || l !== 32'hFFFFFFFF || h !== 32'd5) begin
            errors++; $display("FAIL div_pos_by_zero: got hi=%h lo=%h want hi=5 lo=ffffffff", h, l);
        end
        $display("DIV 5/0: hi=%h lo=%h", h, l);
    endtask

    task automatic test_div_overflow();
        int cyc; bit got; logic [31:0] h, l;
        launch(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || l !== 32'h80000000 || h !== 32'h0) begin
            errors++; $display("FAIL div_overflow: got hi=%h lo=%h want hi=0 lo=80000000", h, l);
        end
        $display("DIV 80000000/-1: hi=%h lo=%h", h, l);
    endtask

    task automatic test_move();
        launch(MDU_MTHI, 32'd5, 32'd0);
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL mthi_value: got %h want 5", hi); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mthi_handshake: got done=%b busy=%b want 0 0", done, busy);
        end
        launch(MDU_MTLO, 32'h1234ABCD, 32'd0);
        checks++; if (lo !== 32'h1234ABCD || hi !== 32'd5) begin
            errors++; $display("FAIL mtlo_value: got hi=%h lo=%h want hi=5 lo=1234abcd", hi, lo);
        end
        launch(MDU_MFHI, 32'hDEADBEEF, 32'hDEADBEEF);
        checks++; if (busy !== 1'b0 || hi !== 32'd5 || lo !== 32'h1234ABCD) begin
            errors++; $display("FAIL mfhi_no_effect: got busy=%b hi=%h lo=%h want 0 5 1234abcd", busy, hi, lo);
        end
        launch(4'd15, 32'hDEADBEEF, 32'h1);
        checks++; if (busy !== 1'b0 || hi !== 32'd5) begin
            errors++; $display("FAIL unknown_op: got busy=%b hi=%h want 0 5", busy, hi);
        end
        $display("move: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_busy_ignore();
        int cyc; bit got; logic [31:0] h, l;
        launch(MDU_MULTU, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        launch(MDU_MTHI, 32'hDEAD0000, 32'd0);
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL mthi_while_busy: got %h want 5", hi); end
        launch(MDU_DIVU, 32'd100, 32'd3);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || h !== 32'd0 || l !== 32'd42) begin
            errors++; $display("FAIL start_while_busy: got hi=%h lo=%h want hi=0 lo=42", h, l);
        end
        $display("busy_ignore: hi=%h lo=%h", h, l);
    endtask

    task automatic test_flush();
        int done_seen;
        launch(MDU_MTHI, 32'h11111111, 32'd0);
        launch(MDU_MTLO, 32'h22222222, 32'd0);
        launch(MDU_MULT, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", done_seen); end
        checks++; if (hi !== 32'h11111111 || lo !== 32'h22222222) begin
            errors++; $display("FAIL flush_hilo_kept: got hi=%h lo=%h want 11111111 22222222", hi, lo);
        end
        flush = 1'b1;
        launch(MDU_MULT, 32'd3, 32'd5);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start: got busy=%b want 0", busy); end
        $display("flush: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back();
        int cyc; bit got; logic [31:0] h, l;
        launch(MDU_MULTU, 32'd2, 32'd3);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || l !== 32'd6 || h !== 32'd0) begin
            errors++; $display("FAIL b2b_first: got hi=%h lo=%h want 0 6", h, l);
        end
        launch(MDU_DIVU, 32'd100, 32'd7);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_relaunch: got done=%b busy=%b want 0 1", done, busy);
        end
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || l !== 32'd14 || h !== 32'd2 || cyc != 33) begin
            errors++; $display("FAIL b2b_second: got hi=%h lo=%h cyc=%0d want 2 14 33", h, l, cyc);
        end
        $display("back_to_back: hi=%h lo=%h", h, l);
    endtask

    task automatic test_madd();
`ifdef MDU_MADD_EN
        int cyc; bit got; logic [31:0] h, l;
        launch(MDU_MTHI, 32'd0, 32'd0);
        launch(MDU_MTLO, 32'd10, 32'd0);
        launch(MDU_MADD, 32'd3, 32'd4);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || h !== 32'd0 || l !== 32'd22) begin
            errors++; $display("FAIL madd: got hi=%h lo=%h want 0 22", h, l);
        end
        launch(MDU_MSUB, 32'hFFFFFFFE, 32'd5);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || h !== 32'd0 || l !== 32'd32) begin
            errors++; $display("FAIL msub_signed: got hi=%h lo=%h want 0 32", h, l);
        end
        launch(MDU_MSUBU, 32'd11, 32'd3);
        wait_done(cyc, got, h, l);
        checks++; if (got !== 1'b1 || h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL msubu_wrap: got hi=%h lo=%h want ffffffff ffffffff", h, l);
        end
        $display("madd: hi=%h lo=%h", h, l);
`else
        launch(MDU_MADD, 32'd3, 32'd4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL madd_disabled: got busy=%b want 0", busy); end
        $display("madd disabled: busy=%b", busy);
`endif
    endtask

    task automatic test_rst_mid_div();
        launch(MDU_MTHI, 32'hAAAA5555, 32'd0);
        launch(MDU_DIV, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_div: got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("rst_mid_div: hi=%h lo=%h busy=%b", hi, lo, busy);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_div_overflow();
        test_move();
        test_busy_ignore();
        test_flush();
        test_back_to_back();
        test_madd();
        test_rst_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
